audio_tone_gen: RTL and testbench
=================================

# audio_tone_gen

Parametrised multi-channel audio test-tone generator. It produces one signed sample per channel per push into the audio CDC FIFO's write side, and throttles itself on that FIFO's full flag. It generalises the fixed two-channel falling sawtooth to N channels with per-channel frequency, waveform, attenuation and phase sync. It sits in the system clock domain, ahead of the live-audio serialiser.

## Interface
Parameters:
- AUDIO_WIDTH, 16, sample width per channel (signed two's complement)
- CHANNELS, 2, channel count (≥1)
- PHASE_WIDTH, 24, phase accumulator width (must be ≥ AUDIO_WIDTH)

Ports (packed buses: channel c occupies slice [(CHANNELS-c)*N-1 -: N], so channel 0 is most significant, i.e. left):
- clk  in  1  system clock; sole clock
- reset  in  1  synchronous, active-high
- run  in  1  1 = generate; 0 = stall, with phases held
- sync  in  1  one-cycle pulse; clears all phase accumulators
- inc  in  CHANNELS*PHASE_WIDTH  per-channel phase increment per sample (unsigned)
- mode  in  CHANNELS*2  per-channel waveform: 0 saw, 1 square, 2 triangle, 3 mute
- shift  in  CHANNELS*3  per-channel arithmetic right shift (attenuation 0..7)
- sample_full  in  1  FIFO full flag from the write side
- sample_en  out  1  write strobe to the FIFO
- sample_data  out  CHANNELS*AUDIO_WIDTH  packed samples; valid when sample_en=1
- sample_count  out  32  number of pushes since reset; wraps modulo 2^32

## Operation
- Reset (sync, active-high) sets every register to zero: phase[c], sample_en, sample_data, sample_count.
- Push condition: push = run & ~sample_full, evaluated every cycle out of reset.
- On push:
  - sample_en ← 1.
  - sample[c] ← gain(wave(phase[c])), using the **pre-increment** phase.
  - phase[c] ← phase[c] + inc[c] mod 2^PHASE_WIDTH.
  - sample_count ← sample_count + 1.
- On no push:
  - sample_en ← 0.
  - sample_data holds its last value.
  - Phases and count hold.
- sync=1 forces phase[c] ← 0 for all c, overriding the increment. If a push coincides with sync, that push's sample still uses the old phase. sync has no effect on sample_en or sample_count.
- Waveform, with p = phase[c][PHASE_WIDTH-1 -: AUDIO_WIDTH] (unsigned), M = p's MSB, H = 2^(AUDIO_WIDTH-1):
  - saw (0): p − H, i.e. p with the MSB inverted; rising ramp, p=0 → −H.
  - square (1): M=0 → H−1; M=1 → −H.
  - triangle (2): M=0 → (p[W-2:0]<<1) − H; M=1 → ((~p[W-2:0])<<1) − H. The result is in −H..H−2.
  - mute (3): 0.
- gain: signed arithmetic shift right by shift[c]; sign preserved, truncation toward −∞.
- mode, shift and inc are sampled at each push. A change takes effect on the next push; there is no glitch handling.

## Timing
- Single registered stage: sample_en and sample_data update on the same clock edge, both from state present before that edge.
- sample_full=1 in cycle n → sample_en=0 in cycle n+1. With run=1, sample_full=0 held → sample_en=1 every cycle.
- First push after reset deassertion: the cycle after reset is low with run=1 and full=0. That push carries wave(0) for every channel.
- Back-to-back pushes: no bubble.
- Full/run deassertion resumes exactly at the held phase; no sample is skipped or repeated.
- Phase wrap: pure modulo arithmetic; inc=0 gives a constant sample.
- Reset asserted mid-stream: on the next edge all outputs are 0 regardless of run, full or sync.

## Test plan
- **Reset and ramp:** hold reset 4 cycles with run=1, full=0 → sample_en=0 and data=0. Release with ch0 saw, inc0=0x000100, shift0=0 → ch0 samples −32768, −32767, −32766 on consecutive cycles; sample_count 1, 2, 3.
- **Backpressure:** after 2 pushes of the ramp above, full=1 for 5 cycles → sample_en=0 from the following cycle, count holds at 2. Then full=0 → next sample −32766, no repeat and no skip.
- **Square and triangle:** inc=0x400000.
  - Square sequence: 32767, 32767, −32768, −32768, repeating.
  - Triangle sequence: −32768, 0, 32766, −2, repeating.
- **Gain and mute:** saw with shift=3 → first sample −4096. mode=3 with any shift → 0 on every push.
- **Sync and wrap:** inc=0x000100, 65536 pushes → phase wraps and sample returns to −32768. Pulse sync coincident with a push → that sample uses the old phase, and the next sample is −32768.
- **Multichannel packing:** CHANNELS=4 with ch0 mute, ch1 square, ch2 saw, ch3 mute, all inc=0 → first push sample_data = {0x0000, 0x7FFF, 0x8000, 0x0000}.

Source files
------------

// File: rtl/audio_tone_gen.sv
// Multi-channel audio test-tone generator: saw/square/triangle/mute per channel,
// with per-channel attenuation, phase sync and FIFO-full throttling.
module audio_tone_gen #(
   parameter int AUDIO_WIDTH = 16,
   parameter int CHANNELS    = 2,
   parameter int PHASE_WIDTH = 24
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            run,
   input  logic                            sync,
   input  logic [CHANNELS*PHASE_WIDTH-1:0] inc,
   input  logic [CHANNELS*2-1:0]           mode,
   input  logic [CHANNELS*3-1:0]           shift,
   input  logic                            sample_full,
   output logic                            sample_en,
   output logic [CHANNELS*AUDIO_WIDTH-1:0] sample_data,
   output logic [31:0]                     sample_count
);

   localparam int W = AUDIO_WIDTH;

   logic [PHASE_WIDTH-1:0]  phase_q [CHANNELS];
   logic [PHASE_WIDTH-1:0]  phase_d [CHANNELS];
   logic [CHANNELS*W-1:0]   sample_q, sample_d;
   logic                    en_q, en_d;
   logic [31:0]             count_q, count_d;
   logic                    push;

   // Waveform shaping on the top W bits of the phase; "- H" is an MSB flip.
   function automatic logic signed [W-1:0] wave_f(input logic [W-1:0] p,
                                                  input logic [1:0]   md);
      logic signed [W-1:0] r;
      r = '0;
      case (md)
         2'd0: r = {~p[W-1], p[W-2:0]};
         2'd1: r = p[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         2'd2: r = p[W-1] ? {p[W-2], ~p[W-3:0], 1'b0}
                          : {~p[W-2], p[W-3:0], 1'b0};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic signed [W-1:0] gain_f(input logic signed [W-1:0] x,
                                                  input logic [2:0]          sh);
      return x >>> sh;
   endfunction

   always_comb begin
      push     = run & ~sample_full;
      en_d     = push;
      sample_d = sample_q;
      count_d  = push ? count_q + 32'd1 : count_q;
      for (int c = 0; c < CHANNELS; c++) begin
         phase_d[c] = phase_q[c];
         if (push) begin
            sample_d[(CHANNELS-c)*W-1 -: W] =
               gain_f(wave_f(phase_q[c][PHASE_WIDTH-1 -: W],
                             mode[(CHANNELS-c)*2-1 -: 2]),
                      shift[(CHANNELS-c)*3-1 -: 3]);
            phase_d[c] = phase_q[c] + inc[(CHANNELS-c)*PHASE_WIDTH-1 -: PHASE_WIDTH];
         end
         // sync wins over the increment but not over the sample of this push
         if (sync) phase_d[c] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q     <= 1'b0;
         sample_q <= '0;
         count_q  <= '0;
         for (int c = 0; c < CHANNELS; c++) phase_q[c] <= '0;
      end else begin
         en_q     <= en_d;
         sample_q <= sample_d;
         count_q  <= count_d;
         for (int c = 0; c < CHANNELS; c++) phase_q[c] <= phase_d[c];
      end
   end

   assign sample_en    = en_q;
   assign sample_data  = sample_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed bench for audio_tone_gen (4 channels, ch0 most significant).
module tb_audio_tone_gen;

   localparam int AW = 16;
   localparam int CH = 4;
   localparam int PW = 24;

   logic              clk = 1'b0;
   logic              reset, run, sync, sample_full;
   logic [CH*PW-1:0]  inc;
   logic [CH*2-1:0]   mode;
   logic [CH*3-1:0]   shift;
   logic              sample_en;
   logic [CH*AW-1:0]  sample_data;
   logic [31:0]       sample_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   audio_tone_gen #(.AUDIO_WIDTH(AW), .CHANNELS(CH), .PHASE_WIDTH(PW)) dut (
      .clk(clk), .reset(reset), .run(run), .sync(sync), .inc(inc),
      .mode(mode), .shift(shift), .sample_full(sample_full),
      .sample_en(sample_en), .sample_data(sample_data),
      .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One pushing cycle: checks strobe, ch0 sample and the running count.
   task automatic push_chk(input string tag, input logic [15:0] exp_ch0);
      tick();
      exp_cnt++;
      chk({tag, "_en"}, 64'(sample_en), 64'd1);
      chk({tag, "_ch0"}, 64'(sample_data[CH*AW-1 -: AW]), 64'(exp_ch0));
      chk({tag, "_cnt"}, 64'(sample_count), 64'(exp_cnt));
   endtask

   initial begin
      reset = 1'b1; run = 1'b1; sync = 1'b0; sample_full = 1'b0;
      inc   = {24'h000100, 72'h0};
      mode  = {2'd0, 2'd3, 2'd3, 2'd3};
      shift = '0;
      repeat (4) tick();
      chk("rst_en",   64'(sample_en), 64'd0);
      chk("rst_data", sample_data, 64'd0);
      chk("rst_cnt",  64'(sample_count), 64'd0);

      reset = 1'b0;
      push_chk("ramp0", 16'h8000);
      push_chk("ramp1", 16'h8001);

      sample_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_en",   64'(sample_en), 64'd0);
         chk("bp_cnt",  64'(sample_count), 64'd2);
         chk("bp_hold", 64'(sample_data[CH*AW-1 -: AW]), 64'h8001);
      end
      sample_full = 1'b0;
      push_chk("resume0", 16'h8002);
      push_chk("resume1", 16'h8003);

      run = 1'b0;
      tick();
      chk("stall_en", 64'(sample_en), 64'd0);
      run = 1'b1;
      push_chk("run_resume", 16'h8004);

      sync = 1'b1;
      push_chk("sync_old", 16'h8005);
      sync = 1'b0;
      shift = {3'd3, 9'd0};
      push_chk("gain0", 16'hF000);
      push_chk("gain1", 16'hF000);
      push_chk("gain2", 16'hF000);
      mode  = {2'd3, 2'd3, 2'd3, 2'd3};
      shift = {3'd5, 9'd0};
      push_chk("mute", 16'h0000);
      chk("mute_all", sample_data, 64'd0);

      run = 1'b0; sync = 1'b1;
      tick();
      sync = 1'b0; run = 1'b1;
      inc   = {24'h400000, 72'h0};
      mode  = {2'd1, 2'd3, 2'd3, 2'd3};
      shift = '0;
      push_chk("sq0", 16'h7FFF);
      push_chk("sq1", 16'h7FFF);
      push_chk("sq2", 16'h8000);
      push_chk("sq3", 16'h8000);
      push_chk("sq4", 16'h7FFF);

      run = 1'b0; sync = 1'b1;
      tick();
      sync = 1'b0; run = 1'b1;
      mode = {2'd2, 2'd3, 2'd3, 2'd3};
      push_chk("tri0", 16'h8000);
      push_chk("tri1", 16'h0000);
      push_chk("tri2", 16'h7FFE);
      push_chk("tri3", 16'hFFFE);
      push_chk("tri4", 16'h8000);

      run = 1'b0; sync = 1'b1;
      tick();
      sync = 1'b0; run = 1'b1;
      inc  = {24'h000100, 72'h0};
      mode = {2'd0, 2'd3, 2'd3, 2'd3};
      push_chk("wrap_first", 16'h8000);
      repeat (65534) tick();
      exp_cnt += 65534;
      push_chk("wrap_top", 16'h7FFF);
      push_chk("wrap_back", 16'h8000);

      run = 1'b0; sync = 1'b1;
      tick();
      sync = 1'b0; run = 1'b1;
      inc  = '0;
      mode = {2'd3, 2'd1, 2'd0, 2'd3};
      push_chk("pack0", 16'h0000);
      chk("pack0_all", sample_data, 64'h0000_7FFF_8000_0000);
      push_chk("pack1", 16'h0000);
      chk("pack1_all", sample_data, 64'h0000_7FFF_8000_0000);

      reset = 1'b1; sync = 1'b1;
      tick();
      chk("midrst_en",   64'(sample_en), 64'd0);
      chk("midrst_data", sample_data, 64'd0);
      chk("midrst_cnt",  64'(sample_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
